// File: rtl/raid_pkg.sv
// Shared types and constants for the RAID rebuild stage that follows the
// 3-disk rotating-parity memory.
package raid_pkg;

  localparam int DATA_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_RD,
    WAIT_RD,
    ISSUE_WR,
    WAIT_WR,
    DONE,
    ERROR
  } rebuild_state_t;

  // Surviving-pair select codes understood by the memory read port
  localparam logic [1:0] RD_PAIR_01 = 2'b01;
  localparam logic [1:0] RD_PAIR_02 = 2'b10;
  localparam logic [1:0] RD_PAIR_12 = 2'b11;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_STAT = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage

// File: rtl/raid_fail_decode.sv
// Maps the memory's disk status word to the surviving read pair and the
// one-hot write enable of the failed disk; flags any status without exactly one 0.
module raid_fail_decode (
  input  logic [2:0] disk_stat,
  output logic       legal,
  output logic [1:0] en_rd_mem,
  output logic [2:0] en_wr_mem
);
  import raid_pkg::*;

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; an unassigned path in always_comb infers a latch.
  always_comb begin
    legal     = 1'b0;
    en_rd_mem = 2'b00;
    en_wr_mem = 3'b000;
    unique case (disk_stat)
      3'b110: begin legal = 1'b1; en_rd_mem = RD_PAIR_12; en_wr_mem = 3'b001; end
      3'b101: begin legal = 1'b1; en_rd_mem = RD_PAIR_02; en_wr_mem = 3'b010; end
      3'b011: begin legal = 1'b1; en_rd_mem = RD_PAIR_01; en_wr_mem = 3'b100; end
      default: ;
    endcase
  end

endmodule

// File: rtl/raid_rebuild_ctrl.sv
// Rebuilds a zeroed failed disk: reads the surviving pair at each address,
// XORs the two words and writes the result back to the failed disk.
module raid_rebuild_ctrl #(
  parameter int SIZE    = 4,
  parameter int DATA_W  = raid_pkg::DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              zero_done,
  input  logic [2:0]        disk_stat_in,
  input  logic [DATA_W-1:0] rd_data_A,
  input  logic [DATA_W-1:0] rd_data_B,
  input  logic [7:0]        mem_addr_in,
  input  logic              mem_rd_ack,
  input  logic              mem_wr_ack,
  output logic              rd_valid,
  output logic [1:0]        en_rd_mem,
  output logic [7:0]        add,
  output logic              wr_valid,
  output logic [2:0]        en_wr_mem,
  output logic [7:0]        address,
  output logic [DATA_W-1:0] wr_disk0,
  output logic [DATA_W-1:0] wr_disk1,
  output logic [DATA_W-1:0] wr_disk2,
  output logic              rebuild_busy,
  output logic              rebuild_done,
  output logic [1:0]        rebuild_err
);
  import raid_pkg::*;

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  rebuild_state_t    state_q, state_d;
  logic              zd_q;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [1:0]        rd_sel_q, rd_sel_d;
  logic [2:0]        wr_sel_q, wr_sel_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              rd_valid_q, rd_valid_d;
  logic [1:0]        en_rd_q, en_rd_d;
  logic [7:0]        add_q, add_d;
  logic              wr_valid_q, wr_valid_d;
  logic [2:0]        en_wr_q, en_wr_d;
  logic [7:0]        address_q, address_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;

  logic       stat_legal;
  logic [1:0] dec_rd;
  logic [2:0] dec_wr;
  logic       start, rd_match, wr_match, last_idx, timed_out;

  raid_fail_decode u_fail_decode (
    .disk_stat (disk_stat_in),
    .legal     (stat_legal),
    .en_rd_mem (dec_rd),
    .en_wr_mem (dec_wr)
  );

  assign start     = zero_done & ~zd_q;
  // Acks for any address other than the one in flight are stale and ignored
  assign rd_match  = mem_rd_ack && (mem_addr_in == 8'(idx_q));
  assign wr_match  = mem_wr_ack && (mem_addr_in == 8'(idx_q));
  assign last_idx  = (idx_q == IDX_W'(SIZE - 1));
  assign timed_out = (timer_q == TMR_W'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    rd_sel_d = rd_sel_q;
    wr_sel_d = wr_sel_q;
    word_d   = word_q;
    err_d    = err_q;

    case (state_q)
      IDLE, ERROR: begin
        if (start) begin
          idx_d = '0;
          if (stat_legal) begin
            err_d    = ERR_NONE;
            rd_sel_d = dec_rd;
            wr_sel_d = dec_wr;
            state_d  = ISSUE_RD;
          end else begin
            err_d   = ERR_STAT;
            state_d = ERROR;
          end
        end
      end
      ISSUE_RD: begin
        timer_d = '0;
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (rd_match) begin
          word_d  = rd_data_A ^ rd_data_B;
          state_d = ISSUE_WR;
        end else if (timed_out) begin
          err_d   = ERR_TMO;
          state_d = ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ISSUE_WR: begin
        timer_d = '0;
        state_d = WAIT_WR;
      end
      WAIT_WR: begin
        if (wr_match) begin
          if (last_idx) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ISSUE_RD;
          end
        end else if (timed_out) begin
          err_d   = ERR_TMO;
          state_d = ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered and glitch-free
    rd_valid_d = (state_d == ISSUE_RD);
    en_rd_d    = (state_d == ISSUE_RD) ? rd_sel_d : 2'b00;
    add_d      = (state_d == ISSUE_RD) ? 8'(idx_d) : add_q;
    wr_valid_d = (state_d == ISSUE_WR);
    en_wr_d    = (state_d == ISSUE_WR) ? wr_sel_d : 3'b000;
    address_d  = (state_d == ISSUE_WR) ? 8'(idx_d) : address_q;
    busy_d     = (state_d == ISSUE_RD) || (state_d == WAIT_RD) ||
                 (state_d == ISSUE_WR) || (state_d == WAIT_WR);
    done_d     = (state_d == DONE);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      zd_q       <= 1'b0;
      idx_q      <= '0;
      timer_q    <= '0;
      rd_sel_q   <= 2'b00;
      wr_sel_q   <= 3'b000;
      word_q     <= '0;
      rd_valid_q <= 1'b0;
      en_rd_q    <= 2'b00;
      add_q      <= 8'h00;
      wr_valid_q <= 1'b0;
      en_wr_q    <= 3'b000;
      address_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      zd_q       <= zero_done;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      rd_sel_q   <= rd_sel_d;
      wr_sel_q   <= wr_sel_d;
      word_q     <= word_d;
      rd_valid_q <= rd_valid_d;
      en_rd_q    <= en_rd_d;
      add_q      <= add_d;
      wr_valid_q <= wr_valid_d;
      en_wr_q    <= en_wr_d;
      address_q  <= address_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rd_valid     = rd_valid_q;
  assign en_rd_mem    = en_rd_q;
  assign add          = add_q;
  assign wr_valid     = wr_valid_q;
  assign en_wr_mem    = en_wr_q;
  assign address      = address_q;
  assign wr_disk0     = word_q;
  assign wr_disk1     = word_q;
  assign wr_disk2     = word_q;
  assign rebuild_busy = busy_q;
  assign rebuild_done = done_q;
  assign rebuild_err  = err_q;

endmodule

// File: tb/tb_raid_rebuild_ctrl.sv
// Self-checking bench for raid_rebuild_ctrl: a memory stub answers requests
// and a scoreboard holds the expected read and write requests of each pass.
module tb_raid_rebuild_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        zero_done;
  logic [2:0]  disk_stat_in;
  logic [11:0] rd_data_A, rd_data_B;
  logic [7:0]  mem_addr_in;
  logic        mem_rd_ack, mem_wr_ack;
  logic        rd_valid, wr_valid;
  logic [1:0]  en_rd_mem;
  logic [2:0]  en_wr_mem;
  logic [7:0]  add, address;
  logic [11:0] wr_disk0, wr_disk1, wr_disk2;
  logic        rebuild_busy, rebuild_done;
  logic [1:0]  rebuild_err;

  typedef struct {logic [7:0] addr; logic [1:0] en;} rd_exp_t;
  typedef struct {logic [7:0] addr; logic [2:0] en; logic [11:0] data;} wr_exp_t;

  rd_exp_t exp_rd[$];
  wr_exp_t exp_wr[$];

  int checks = 0;
  int errors = 0;

  // Memory stub state
  int          withhold_addr = -1;
  int          stale_addr    = -1;
  bit          stale_done    = 1'b0;
  bit          rd_pend       = 1'b0;
  bit          wr_pend       = 1'b0;
  int          rd_pend_addr  = 0;
  int          wr_pend_addr  = 0;
  logic [11:0] base_a = 12'h000, base_b = 12'h000;
  int          stepv  = 0;

  always #5 clk = ~clk;

  raid_rebuild_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .zero_done    (zero_done),
    .disk_stat_in (disk_stat_in),
    .rd_data_A    (rd_data_A),
    .rd_data_B    (rd_data_B),
    .mem_addr_in  (mem_addr_in),
    .mem_rd_ack   (mem_rd_ack),
    .mem_wr_ack   (mem_wr_ack),
    .rd_valid     (rd_valid),
    .en_rd_mem    (en_rd_mem),
    .add          (add),
    .wr_valid     (wr_valid),
    .en_wr_mem    (en_wr_mem),
    .address      (address),
    .wr_disk0     (wr_disk0),
    .wr_disk1     (wr_disk1),
    .wr_disk2     (wr_disk2),
    .rebuild_busy (rebuild_busy),
    .rebuild_done (rebuild_done),
    .rebuild_err  (rebuild_err)
  );

  function automatic logic [11:0] da(input int a);
    return base_a ^ 12'(a * stepv);
  endfunction

  function automatic logic [11:0] db(input int a);
    return base_b ^ 12'(a * stepv * 3);
  endfunction

  // One clock: check outputs at the falling edge against the scoreboard, then drive the stub
  task automatic step();
    rd_exp_t re;
    wr_exp_t we;
    @(negedge clk);
    checks++;
    if ((rd_valid && wr_valid) || (!rd_valid && en_rd_mem !== 2'b00) ||
        (!wr_valid && en_wr_mem !== 3'b000)) begin
      errors++;
      $display("FAIL strobes: rd_valid=%b en_rd=%b wr_valid=%b en_wr=%b, required no overlap and idle enables zero",
               rd_valid, en_rd_mem, wr_valid, en_wr_mem);
    end
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd: add=%h en_rd=%b, required no read", add, en_rd_mem);
      end else begin
        re = exp_rd.pop_front();
        if ({add, en_rd_mem} !== {re.addr, re.en}) begin
          errors++;
          $display("FAIL rd_req: add=%h en_rd=%b, required add=%h en_rd=%b", add, en_rd_mem, re.addr, re.en);
        end
      end
    end
    if (wr_valid === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wr: address=%h en_wr=%b", address, en_wr_mem);
      end else begin
        we = exp_wr.pop_front();
        if ({address, en_wr_mem, wr_disk0, wr_disk1, wr_disk2} !== {we.addr, we.en, we.data, we.data, we.data}) begin
          errors++;
          $display("FAIL wr_req: address=%h en_wr=%b data=%h/%h/%h, required address=%h en_wr=%b data=%h",
                   address, en_wr_mem, wr_disk0, wr_disk1, wr_disk2, we.addr, we.en, we.data);
        end
      end
    end
    mem_rd_ack = 1'b0;
    mem_wr_ack = 1'b0;
    if (rd_pend && rd_pend_addr != withhold_addr) begin
      mem_rd_ack = 1'b1;
      if (rd_pend_addr == stale_addr && !stale_done) begin
        mem_addr_in = 8'd5;
        rd_data_A   = 12'hFFF;
        rd_data_B   = 12'h000;
        stale_done  = 1'b1;
      end else begin
        mem_addr_in = 8'(rd_pend_addr);
        rd_data_A   = da(rd_pend_addr);
        rd_data_B   = db(rd_pend_addr);
        rd_pend     = 1'b0;
      end
    end
    if (wr_pend) begin
      mem_wr_ack  = 1'b1;
      mem_addr_in = 8'(wr_pend_addr);
      wr_pend     = 1'b0;
    end
    if (rd_valid === 1'b1) begin rd_pend = 1'b1; rd_pend_addr = int'(add); end
    if (wr_valid === 1'b1) begin wr_pend = 1'b1; wr_pend_addr = int'(address); end
  endtask

  task automatic push_exp(input int n_rd, input int n_wr, input logic [1:0] en_rd,
                          input logic [2:0] en_wr);
    for (int i = 0; i < n_rd; i++) exp_rd.push_back('{addr: 8'(i), en: en_rd});
    for (int i = 0; i < n_wr; i++) exp_wr.push_back('{addr: 8'(i), en: en_wr, data: da(i) ^ db(i)});
  endtask

  // Leaves zero_done freshly raised just after a falling edge
  task automatic start_pass();
    zero_done = 1'b0;
    step();
    step();
    zero_done = 1'b1;
  endtask

  task automatic finish_pass(input string name, input int exp_lat);
    int n = 0;
    do begin step(); n++; end while (rebuild_done !== 1'b1 && n < 200);
    checks++;
    if (rebuild_done !== 1'b1 || n != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: done=%b after %0d cycles, required done after %0d", name, rebuild_done, n, exp_lat);
    end
    checks++;
    if ({rebuild_busy, rebuild_err} !== 3'b000) begin
      errors++;
      $display("FAIL %s_done_flags: busy=%b err=%b, required 0/00", name, rebuild_busy, rebuild_err);
    end
    step();
    checks++;
    if (rebuild_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: done=%b a cycle later, required 0", name, rebuild_done);
    end
    checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d reads %0d writes outstanding, required 0", name, exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({rd_valid, en_rd_mem, add, wr_valid, en_wr_mem, address, wr_disk0, wr_disk1, wr_disk2,
         rebuild_busy, rebuild_done, rebuild_err} !== '0) begin
      errors++;
      $display("FAIL %s: rd=%b enr=%b add=%h wr=%b enw=%b address=%h data=%h busy=%b done=%b err=%b, required all 0",
               name, rd_valid, en_rd_mem, add, wr_valid, en_wr_mem, address, wr_disk0, rebuild_busy,
               rebuild_done, rebuild_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; zero_done = 1'b0; disk_stat_in = 3'b111;
    rd_data_A = '0; rd_data_B = '0; mem_addr_in = '0; mem_rd_ack = 1'b0; mem_wr_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    reset = 1'b0;
    step();
    step();
    check_all_zero("idle_outputs");
  endtask

  task automatic test_disk1();
    base_a = 12'hABC; base_b = 12'h123; stepv = 0;
    disk_stat_in = 3'b101;
    for (int i = 0; i < 4; i++) begin
      exp_rd.push_back('{addr: 8'(i), en: 2'b10});
      exp_wr.push_back('{addr: 8'(i), en: 3'b010, data: 12'hB9F});
    end
    start_pass();
    finish_pass("disk1", 17);
  endtask

  task automatic test_disk0();
    base_a = 12'h5A5; base_b = 12'h3C3; stepv = 12'h111;
    disk_stat_in = 3'b110;
    push_exp(4, 4, 2'b11, 3'b001);
    start_pass();
    step();
    checks++;
    if (rebuild_busy !== 1'b1) begin
      errors++;
      $display("FAIL disk0_busy: busy=%b in first request cycle, required 1", rebuild_busy);
    end
    finish_pass("disk0", 16);
  endtask

  task automatic test_illegal();
    logic [2:0] stats [3] = '{3'b100, 3'b111, 3'b000};
    for (int k = 0; k < 3; k++) begin
      disk_stat_in = stats[k];
      start_pass();
      step();
      checks++;
      if ({rebuild_err, rebuild_busy, rd_valid} !== 4'b0100) begin
        errors++;
        $display("FAIL illegal_%b: err=%b busy=%b rd_valid=%b, required 01/0/0", stats[k], rebuild_err,
                 rebuild_busy, rd_valid);
      end
      repeat (3) step();
      checks++;
      if (rebuild_err !== 2'b01) begin
        errors++;
        $display("FAIL illegal_hold_%b: err=%b, required 01", stats[k], rebuild_err);
      end
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    bit seen = 1'b0;
    base_a = 12'h0F0; base_b = 12'h90F; stepv = 12'h021;
    disk_stat_in = 3'b011;
    withhold_addr = 2;
    push_exp(3, 2, 2'b01, 3'b100);
    start_pass();
    while (!seen && n < 64) begin
      step(); n++;
      if (rd_valid === 1'b1 && add === 8'd2) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL tmo_reach_addr2: no read of addr 2 within %0d cycles", n);
    end
    n = 0;
    do begin step(); n++; end while (rebuild_err !== 2'b10 && n < 64);
    checks++;
    if (rebuild_err !== 2'b10 || n != 17) begin
      errors++;
      $display("FAIL tmo_latency: err=%b after %0d cycles, required 10 after 17", rebuild_err, n);
    end
    checks++;
    if ({rebuild_busy, rd_valid, wr_valid} !== 3'b000) begin
      errors++;
      $display("FAIL tmo_strobes: busy=%b rd=%b wr=%b, required 000", rebuild_busy, rd_valid, wr_valid);
    end
    repeat (3) step();
    checks++;
    if (rebuild_err !== 2'b10) begin
      errors++;
      $display("FAIL tmo_sticky: err=%b, required 10", rebuild_err);
    end
    withhold_addr = -1;
    rd_pend = 1'b0;
    push_exp(4, 4, 2'b01, 3'b100);
    start_pass();
    step();
    checks++;
    if ({rebuild_err, rebuild_busy} !== 3'b001) begin
      errors++;
      $display("FAIL tmo_restart: err=%b busy=%b, required 00/1", rebuild_err, rebuild_busy);
    end
    finish_pass("tmo_restart", 16);
  endtask

  task automatic test_stale_ack();
    base_a = 12'h777; base_b = 12'h1E1; stepv = 12'h105;
    disk_stat_in = 3'b101;
    stale_addr = 1; stale_done = 1'b0;
    push_exp(4, 4, 2'b10, 3'b010);
    start_pass();
    finish_pass("stale", 18);
    stale_addr = -1;
  endtask

  task automatic test_reset_mid_pass();
    int n = 0;
    bit seen = 1'b0;
    base_a = 12'h246; base_b = 12'hFDB; stepv = 12'h0F3;
    disk_stat_in = 3'b101;
    push_exp(2, 2, 2'b10, 3'b010);
    start_pass();
    while (!seen && n < 64) begin
      step(); n++;
      if (wr_valid === 1'b1 && address === 8'd1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_reach_wr1: no write of addr 1 within %0d cycles", n);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    zero_done = 1'b0;
    #1;
    check_all_zero("rst_mid_outputs");
    rd_pend = 1'b0; wr_pend = 1'b0; mem_rd_ack = 1'b0; mem_wr_ack = 1'b0;
    checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_requests: %0d reads %0d writes outstanding, required 0", exp_rd.size(), exp_wr.size());
    end
    @(negedge clk);
    reset = 1'b0;
    push_exp(4, 4, 2'b10, 3'b010);
    start_pass();
    finish_pass("rst_rebuild", 17);
  endtask

  initial begin
    test_reset();
    test_disk1();
    test_disk0();
    test_illegal();
    test_timeout();
    test_stale_ack();
    test_reset_mid_pass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
